// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a 2-entry {instr, pc} buffer, credit-limited requests and redirect flush.
// Optional macro FETCH_MISALIGN_CHECK_EN: flag misaligned redirect targets and halt fetch until an aligned redirect.
`default_nettype none

module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              ILEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] instr_out,
   output logic [XLEN-1:0] instr_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_misaligned
);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_rsp_pc;
   logic [1:0]      r_out_cnt;
   logic [1:0]      r_drop_cnt;
   logic [1:0]      r_fifo_cnt;
   logic [ILEN-1:0] r_fifo_instr [2];
   logic [XLEN-1:0] r_fifo_pc    [2];
   logic            r_rd_ptr;
   logic            r_wr_ptr;
   logic            r_misaligned;

   logic            w_req_valid;
   logic            w_accept;
   logic            w_credit_ok;
   logic            w_rsp_keep;
   logic            w_pop;
   logic [1:0]      w_out_nxt;
   logic [XLEN-1:0] w_redir_pc;
   logic            w_redir_mis;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign w_redir_mis = (redirect_pc[1:0] != 2'b00);
   assign w_redir_pc  = redirect_pc;
`else
   assign w_redir_mis = 1'b0;
   assign w_redir_pc  = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
`endif

   // Outstanding requests plus buffered words may never exceed the buffer depth.
   assign w_credit_ok = (({1'b0, r_out_cnt} + {1'b0, r_fifo_cnt}) < 3'd2);
   assign w_accept    = imem_req_valid && imem_req_ready;
   assign w_out_nxt   = r_out_cnt + {1'b0, w_accept} - {1'b0, imem_rsp_valid};
   assign w_rsp_keep  = imem_rsp_valid && !redirect_valid && (r_drop_cnt == 2'd0);
   assign w_pop       = instr_valid && instr_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_req_valid = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_req_valid = !r_misaligned && w_credit_ok;
         end
         ST_FLUSH: begin
            if (r_drop_cnt == 2'd0 || (imem_rsp_valid && r_drop_cnt == 2'd1)) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
      // Every request still in flight after a redirect belongs to the old stream.
      if (redirect_valid) begin
         w_state_nxt = (w_out_nxt != 2'd0) ? ST_FLUSH : ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= ST_RUN;
         r_pc            <= RESET_PC;
         r_rsp_pc        <= RESET_PC;
         r_out_cnt       <= 2'd0;
         r_drop_cnt      <= 2'd0;
         r_fifo_cnt      <= 2'd0;
         r_rd_ptr        <= 1'b0;
         r_wr_ptr        <= 1'b0;
         r_misaligned    <= 1'b0;
         r_fifo_instr[0] <= '0;
         r_fifo_instr[1] <= '0;
         r_fifo_pc[0]    <= '0;
         r_fifo_pc[1]    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_out_cnt <= w_out_nxt;
         if (redirect_valid) begin
            r_pc         <= w_redir_pc;
            r_rsp_pc     <= w_redir_pc;
            r_drop_cnt   <= w_out_nxt;
            r_fifo_cnt   <= 2'd0;
            r_rd_ptr     <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_misaligned <= w_redir_mis;
         end else begin
            if (w_accept) begin
               r_pc <= r_pc + XLEN'(4);
            end
            if (imem_rsp_valid && r_drop_cnt != 2'd0) begin
               r_drop_cnt <= r_drop_cnt - 2'd1;
            end
            // Kept responses form a contiguous run from the last redirect target.
            if (w_rsp_keep) begin
               r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
               r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
               r_wr_ptr               <= ~r_wr_ptr;
               r_rsp_pc               <= r_rsp_pc + XLEN'(4);
            end
            if (w_pop) begin
               r_rd_ptr <= ~r_rd_ptr;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_rsp_keep} - {1'b0, w_pop};
         end
      end
   end

   assign imem_req_valid   = rst_n && w_req_valid;
   assign imem_req_addr    = rst_n ? r_pc : RESET_PC;
   assign instr_valid      = rst_n && (r_fifo_cnt != 2'd0);
   assign instr_out        = rst_n ? r_fifo_instr[r_rd_ptr] : '0;
   assign instr_pc         = rst_n ? r_fifo_pc[r_rd_ptr] : '0;
   assign fetch_misaligned = rst_n && r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: in-order memory model with configurable latency and an expected-instruction scoreboard for fetch_unit.
`default_nettype none

module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_misaligned;

   always #5 clk = ~clk;

   fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(RST_PC)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req_addr    (imem_req_addr),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instr_out        (instr_out),
      .instr_pc         (instr_pc),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .fetch_misaligned (fetch_misaligned)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        pend[$];
   logic [63:0] sb[$];
   logic [31:0] acc_log[$];
   int          cyc;
   int          lat;
   int          n_cmp;
   int          n_err;
   logic [31:0] exp_next;
   bit          exp_halt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: score consumption, track redirects, record accepts, drive the memory response.
   task automatic cycle();
      logic [63:0] e;
      req_t        r;
      #1;
      if (instr_valid && instr_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_instr", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            chk("sb_instr_pc", instr_pc, e[63:32]);
            chk("sb_instr_out", instr_out, e[31:0]);
         end
      end
      if (redirect_valid) begin
         sb.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
         exp_halt = (redirect_pc[1:0] != 2'b00);
         exp_next = redirect_pc;
`else
         exp_halt = 1'b0;
         exp_next = redirect_pc & 32'hFFFF_FFFC;
`endif
      end
      if (imem_req_valid && imem_req_ready) begin
         r.addr = imem_req_addr;
         r.due  = cyc + lat;
         pend.push_back(r);
         acc_log.push_back(imem_req_addr);
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
         r = pend.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(r.addr);
         if (!exp_halt && r.addr == exp_next) begin
            sb.push_back({r.addr, mem_word(r.addr)});
            exp_next = exp_next + 32'd4;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      pend.delete();
      sb.delete();
      acc_log.delete();
      exp_next = RST_PC;
      exp_halt = 1'b0;
      cycle();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr_out", instr_out, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_req_addr", imem_req_addr, RST_PC);
      chk("rst_misaligned", 32'(fetch_misaligned), 32'd0);
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (!instr_valid && k < 50) begin
         cycle();
         k++;
      end
      chk({tag, "_timeout"}, 32'(instr_valid), 32'd1);
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_pc    = pc;
      redirect_valid = 1'b1;
      cycle();
   endtask

   initial begin
      int k;
      n_cmp = 0; n_err = 0; cyc = 0; lat = 1;
      rst_n = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'd0;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
      @(negedge clk);

      // Reset release, 1-cycle memory, consumer always ready.
      do_reset();
      #1;
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, RST_PC);
      k = 0;
      while (!instr_valid && k < 20) begin
         cycle();
         k++;
      end
      chk("first_valid_latency", 32'(k), 32'd2);
      for (int i = 0; i < 3; i++) begin
         wait_valid("seq");
         chk("seq_pc", instr_pc, 32'(4 * i));
         cycle();
      end

      // Consumer stalled from reset: buffer fills, requests stop, head holds.
      instr_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (instr_valid) chk("stall_head_stable", instr_out, mem_word(32'd0));
      end
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req_low", 32'(imem_req_valid), 32'd0);
      chk("stall_out", instr_out, mem_word(32'd0));
      chk("stall_pc", instr_pc, 32'd0);
      instr_ready = 1'b1;
      cycle();
      chk("release_next_pc", instr_pc, 32'h4);
      repeat (6) cycle();

      // Redirect with two requests in flight and no response in the same cycle.
      lat = 3;
      k = 0;
      while (!(pend.size() == 2 && pend[0].due > cyc) && k < 100) begin
         cycle();
         k++;
      end
      chk("two_outstanding_found", 32'(pend.size()), 32'd2);
      redirect(32'h100);
      chk("flush1_instr_valid", 32'(instr_valid), 32'd0);
      chk("flush1_req_low", 32'(imem_req_valid), 32'd0);
      cycle();
      chk("flush2_req_low", 32'(imem_req_valid), 32'd0);
      cycle();
      chk("flush_exit_req", 32'(imem_req_valid), 32'd1);
      chk("flush_exit_addr", imem_req_addr, 32'h100);
      wait_valid("redir100");
      chk("redir100_pc", instr_pc, 32'h100);

      // Redirect coinciding with a request accept and a response.
      lat = 1;
      redirect(32'h280);
      k = 0;
      while (!(imem_req_valid && pend.size() == 1 && pend[0].due <= cyc) && k < 40) begin
         cycle();
         k++;
      end
      chk("acc_rsp_found", 32'(imem_req_valid), 32'd1);
      redirect(32'h300);
      chk("same_cycle_valid_low", 32'(instr_valid), 32'd0);
      chk("same_cycle_flush_req", 32'(imem_req_valid), 32'd0);
      cycle();
      chk("same_cycle_resume_addr", imem_req_addr, 32'h300);
      wait_valid("redir300");
      chk("redir300_pc", instr_pc, 32'h300);

      // Address wrap at the top of the space.
      redirect(32'hFFFF_FFF8);
      acc_log.delete();
      repeat (12) cycle();
      chk("wrap_enough_reqs", (acc_log.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
      if (acc_log.size() >= 3) begin
         chk("wrap_a0", acc_log[0], 32'hFFFF_FFF8);
         chk("wrap_a1", acc_log[1], 32'hFFFF_FFFC);
         chk("wrap_a2", acc_log[2], 32'h0000_0000);
      end

      // Misaligned redirect target.
      redirect(32'h102);
      acc_log.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("mis_flag_set", 32'(fetch_misaligned), 32'd1);
      repeat (10) cycle();
      chk("mis_no_requests", 32'(acc_log.size()), 32'd0);
      chk("mis_flag_held", 32'(fetch_misaligned), 32'd1);
      redirect(32'h200);
      chk("mis_flag_clear", 32'(fetch_misaligned), 32'd0);
      wait_valid("mis200");
      chk("mis200_pc", instr_pc, 32'h200);
`else
      chk("mis_flag_tied", 32'(fetch_misaligned), 32'd0);
      wait_valid("mis_aligned");
      chk("mis_aligned_pc", instr_pc, 32'h100);
`endif
      repeat (10) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-006 SHALL have port imem_req_addr  output  XLEN  fetch byte address.
REQ-007 SHALL have port imem_rsp_valid  input  1  response valid; responses in request order, at least 1 cycle after acceptance, never back-pressured.
REQ-008 SHALL have port imem_rsp_data  input  ILEN  fetched instruction word.
REQ-009 SHALL have port instr_valid  output  1  instruction available to decode/imm_gen.
REQ-010 SHALL have port instr_ready  input  1  decode consumes instruction.
REQ-011 SHALL have port instr_out  output  ILEN  instruction word, drives imm_gen instr_in.
REQ-012 SHALL have port instr_pc  output  XLEN  address of instr_out.
REQ-013 SHALL have port redirect_valid  input  1  branch/jump/JALR redirect, single-cycle pulse.
REQ-014 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-015 SHALL have port fetch_misaligned  output  1  misaligned redirect target flag.

Function
REQ-016 SHALL hold fetch PC register; request accepted when imem_req_valid && imem_req_ready; PC advances by 4 on acceptance, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 SHALL buffer instructions in a 2-entry in-order FIFO of {instr, pc}; instr_out/instr_pc show FIFO head; instr_valid = FIFO non-empty.
REQ-018 SHALL assert imem_req_valid only in RUN and when outstanding_count + fifo_count < 2 (credit rule; FIFO can never overflow).
REQ-019 SHALL track outstanding_count (0..2): +1 on accept, -1 on response, both same cycle -> unchanged.
REQ-020 SHALL write a response into the FIFO on imem_rsp_valid (unless dropped); instr_valid rises the cycle after imem_rsp_valid (1-cycle latency, no bypass).
REQ-021 SHALL pop FIFO head on instr_valid && instr_ready; simultaneous push and pop keeps count; pop with empty FIFO ignored.
REQ-022 SHALL implement states RUN and FLUSH.
REQ-023 SHALL on redirect_valid (any state): load PC with redirect_pc, empty FIFO, set drop_count = outstanding requests including one accepted in the same cycle minus a response arriving the same cycle (that response discarded).
REQ-024 SHALL go to FLUSH if drop_count after redirect > 0, else remain/return to RUN.
REQ-025 SHALL in FLUSH suppress imem_req_valid, discard each response (decrement drop_count), go to RUN the cycle drop_count reaches 0.
REQ-026 SHALL keep instr_valid low the cycle after a redirect; first redirected instruction carries instr_pc = redirect_pc.
REQ-027 SHALL hold instr_out/instr_pc stable while instr_valid && !instr_ready.

Reset
REQ-028 SHALL on rst_n low at a clock edge: PC = RESET_PC, FIFO empty, outstanding_count = 0, drop_count = 0, state RUN, fetch_misaligned = 0, halt flag clear.
REQ-029 SHALL drive imem_req_valid = 0, instr_valid = 0, instr_out = 0, instr_pc = 0, imem_req_addr = RESET_PC while rst_n is low.
REQ-030 SHALL issue the first request (addr RESET_PC) in the first cycle rst_n is high; responses arriving after reset to pre-reset requests are the environment's responsibility (memory also reset).

Configuration
REQ-031 SHALL with FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 sets fetch_misaligned = 1 (held) and halts requests until next aligned redirect, which clears it.
REQ-032 SHALL without FETCH_MISALIGN_CHECK_EN: redirect_pc[1:0] treated as 2'b00 and fetch_misaligned tied 0.

Verification
REQ-033 Reset release, RESET_PC=0, memory 1-cycle latency, instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8; first instr_valid 2 cycles after first request accept.
REQ-034 instr_ready=0 for 10 cycles -> FIFO holds 2, imem_req_valid low, instr_out stable at 0x00000000 word; release -> 0x4 follows without loss/duplication.
REQ-035 Redirect to 0x100 with 2 outstanding -> both responses dropped, state FLUSH 2 cycles, next instr_pc = 0x100.
REQ-036 Redirect same cycle as accept and response -> correct drop_count, no stale instruction reaches instr_out.
REQ-037 PC at 0xFFFFFFFC -> next request addr 0x00000000.
REQ-038 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> fetch_misaligned=1, no requests; redirect 0x200 -> flag clear, fetch 0x200; without macro, 0x102 fetches 0x100.
